instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

- Instruction fetch and control stage of the 8-bit single-cycle processor, sitting directly upstream of the register file.
- Holds a loadable instruction memory and the program counter.
- Each cycle it presents one 8-bit `instr_code` together with the decoded `regwrite`, `RsCont` and `alu_op` controls consumed by the register file and ALU.
- A small run-control state machine handles program loading, execution, jumps and halt.

## Interface
Parameters:
- `PC_W`, 6: program counter width; instruction memory depth is 2^PC_W.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low.
- `load_valid`  in  1  instruction memory write strobe.
- `load_addr`  in  PC_W  write address.
- `load_data`  in  8  instruction written.
- `run`  in  1  start request, sampled on rising edge.
- `instr_code`  out  8  current instruction to register file.
- `regwrite`  out  1  register file write enable.
- `RsCont`  out  1  source select: 1 selects `instr[5:3]`, 0 selects `instr[2:0]`.
- `alu_op`  out  2  ALU operation for the current instruction.
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.

## Operation
Instruction format:
- `[7:6]` opcode, `[5:3]` rd, `[2:0]` rs or immediate.

Opcodes:
- 00 MOV: `regwrite`=1, `RsCont`=0, `alu_op`=00 (pass).
- 01 ADD: `regwrite`=1, `RsCont`=1, `alu_op`=01 (rd + rs).
- 10 JMP: `regwrite`=0, `RsCont`=0, `alu_op`=00. Next pc = pc + sign-extended `instr[5:0]`, modulo 2^PC_W.
- 11 with `[5:0]`=6'h3F is HALT. Any other 11 encoding is NOP. Both have `regwrite`=0, `RsCont`=0, `alu_op`=00.

States:
- IDLE (reset state): `load_valid` writes `load_data` into `imem[load_addr]` at the clock edge. `run`=1 moves to RUN with pc=0.
- RUN: `instr_code` = `imem[pc]`, combinational read. Controls are decoded from it. At each edge pc takes pc+1 (wrap 2^PC_W-1 → 0), the JMP target, or holds on HALT. HALT moves to HALTED. `load_valid` is ignored. `run` is ignored.
- HALTED: pc holds at the HALT address. `load_valid` writes as in IDLE. `run`=1 moves to RUN with pc=0.

Outside RUN:
- `instr_code` = 8'hFF.
- `regwrite`=0, `RsCont`=0, `alu_op`=00.

Boundary rules:
- `load_valid` and `run` in the same IDLE/HALTED cycle: the write lands at that edge, and the first RUN fetch sees the new contents.
- JMP offset 0 loops on itself indefinitely.
- Memory contents are not cleared by reset. Memory retains data across reset.

## Timing
- Reset (asynchronous assert, any state, including mid-RUN): state IDLE, pc=0, `busy`=0, `halted`=0, `instr_code`=8'hFF, `regwrite`=0, `RsCont`=0, `alu_op`=00. Takes effect immediately, without waiting for a clock edge.
- Deassertion is synchronized by the system. The first `run` is honoured at the first rising edge after deassertion.
- `run` sampled high at edge N: `busy`=1, pc=0 and instruction 0 are presented from edge N until N+1.
- Each instruction occupies exactly one cycle. The register file write and the pc update occur on the same rising edge that ends the instruction's cycle.
- HALT presented in cycle K: `regwrite`=0 during K. `halted`=1 and `busy`=0 from the edge ending K.
- Memory write latency: a write at edge N is readable from edge N onward.

## Test plan
- Reset mid-RUN at pc=5 → outputs immediately at reset values: pc=0, `instr_code`=FF, `regwrite`=0, state IDLE.
- Load {0x0A (MOV r1,r2), 0x4B (ADD r1,r3), 0xFF}, then pulse `run`:
  - cycle 0: `instr_code`=0A, `regwrite`=1, `RsCont`=0, `alu_op`=00.
  - cycle 1: `instr_code`=4B, `regwrite`=1, `RsCont`=1, `alu_op`=01.
  - cycle 2: `instr_code`=FF, `regwrite`=0.
  - then `halted`=1 with pc=2.
- JMP: `imem[3]`=0xBE (offset −2) → pc sequence 0,1,2,3,1,2,3,1…
- JMP 0x81 at address 63 → pc=0. A sequential fetch from 63 with no jump also wraps to pc=0.
- In IDLE, assert `load_valid` (addr 0, data 0xFF) and `run` in the same cycle → the first RUN cycle shows `instr_code`=FF, then HALTED.
- `load_valid` during RUN with addr=pc+1 and data=0xFF → memory unchanged; execution continues past that address without halting.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-stage bundle: program-load and run requests in, current instruction, decoded controls and run status out.
// Master side drives load/run, slave side is the fetch controller; no backpressure on any signal.
interface instr_fetch_ctrl_if #(
   parameter int PC_W = 6
);
   logic            load_valid;
   logic [PC_W-1:0] load_addr;
   logic [7:0]      load_data;
   logic            run;
   logic [7:0]      instr_code;
   logic            regwrite;
   logic            RsCont;
   logic [1:0]      alu_op;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            halted;

   modport master (
      output load_valid, load_addr, load_data, run,
      input  instr_code, regwrite, RsCont, alu_op, pc, busy, halted
   );

   modport slave (
      input  load_valid, load_addr, load_data, run,
      output instr_code, regwrite, RsCont, alu_op, pc, busy, halted
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory, program counter and run-control FSM; one instruction per cycle, combinational fetch.
// No backpressure: memory writes are accepted in IDLE/HALTED only, and the pc advances every RUN cycle.
module instr_fetch_ctrl #(
   parameter int PC_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   instr_fetch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   state_t          state;
   logic [PC_W-1:0] pc_q;
   logic            busy_q;
   logic            halted_q;

   // Deliberately unreset so a loaded program survives a reset
   logic [7:0]      imem [2**PC_W];

   logic            mem_we;
   logic [7:0]      fetch;
   logic [1:0]      opcode;
   logic            is_halt;
   logic            is_jmp;
   logic [PC_W-1:0] jmp_ofs;
   logic [PC_W-1:0] pc_jmp;
   logic [PC_W-1:0] pc_inc;

   assign mem_we = bus.load_valid && (state != RUN);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         imem[bus.load_addr] <= bus.load_data;
      end
   end

   // Outside RUN the fetch is forced to FF, which decodes to all controls inactive
   always_comb begin
      fetch   = (state == RUN) ? imem[pc_q] : 8'hFF;
      opcode  = fetch[7:6];
      is_halt = (fetch == 8'hFF);
      is_jmp  = (opcode == 2'b10);
      jmp_ofs = PC_W'($signed(fetch[5:0]));
      pc_jmp  = pc_q + jmp_ofs;
      pc_inc  = pc_q + PC_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pc_q     <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (bus.run) begin
                  state    <= RUN;
                  pc_q     <= '0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            RUN: begin
               if (is_halt) begin
                  state    <= HALTED;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if (is_jmp) begin
                  pc_q <= pc_jmp;
               end else begin
                  pc_q <= pc_inc;
               end
            end
            default: begin
               state    <= IDLE;
               pc_q     <= '0;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_code = fetch;
   assign bus.regwrite   = ~opcode[1];
   assign bus.RsCont     = (opcode == 2'b01);
   assign bus.alu_op     = {1'b0, (opcode == 2'b01)};
   assign bus.pc         = pc_q;
   assign bus.busy       = busy_q;
   assign bus.halted     = halted_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed program scenarios plus randomized load/run traffic, all
// compared every cycle against an instruction-level model of the fetch stage.
module tb_instr_fetch_ctrl;
   localparam int PC_W  = 6;
   localparam int DEPTH = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   instr_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

   instr_fetch_ctrl #(.PC_W(PC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Model: 0 = idle, 1 = running, 2 = halted
   int         m_mode = 0;
   int         m_pc   = 0;
   logic [7:0] m_mem [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_instr();
      return (m_mode == 1) ? m_mem[m_pc] : 8'hFF;
   endfunction

   task automatic check_outputs();
      logic [7:0] ins;
      int         op;
      ins = m_instr();
      op  = int'(ins) / 64;
      chk("instr_code", bus.instr_code, ins);
      chk("regwrite",   bus.regwrite,   (m_mode == 1 && op < 2) ? 1 : 0);
      chk("RsCont",     bus.RsCont,     (m_mode == 1 && op == 1) ? 1 : 0);
      chk("alu_op",     bus.alu_op,     (m_mode == 1 && op == 1) ? 1 : 0);
      chk("pc",         bus.pc,         m_pc);
      chk("busy",       bus.busy,       (m_mode == 1) ? 1 : 0);
      chk("halted",     bus.halted,     (m_mode == 2) ? 1 : 0);
   endtask

   task automatic model_step(input logic lv, input int la, input logic [7:0] ld, input logic rn);
      int ins;
      int off;
      if (m_mode == 1) begin
         ins = int'(m_mem[m_pc]);
         if (ins == 255) begin
            m_mode = 2;
         end else if (ins / 64 == 2) begin
            off = ins % 64;
            if (off >= 32) off = off - 64;
            m_pc = ((m_pc + off) % DEPTH + DEPTH) % DEPTH;
         end else begin
            m_pc = (m_pc + 1) % DEPTH;
         end
      end else begin
         if (lv) m_mem[la] = ld;
         if (rn) begin
            m_mode = 1;
            m_pc   = 0;
         end
      end
   endtask

   // Called just after a rising edge; returns just after the next one
   task automatic cycle(input logic lv, input int la, input logic [7:0] ld, input logic rn);
      bus.load_valid = lv;
      bus.load_addr  = la[PC_W-1:0];
      bus.load_data  = ld;
      bus.run        = rn;
      @(negedge clk);
      check_outputs();
      model_step(lv, la, ld, rn);
      @(posedge clk);
      #1;
      bus.load_valid = 1'b0;
      bus.run        = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 8'h00, 1'b0);
   endtask

   task automatic async_reset();
      reset = 1'b0;
      #2;
      chk("rst_instr_code", bus.instr_code, 8'hFF);
      chk("rst_regwrite",   bus.regwrite,   0);
      chk("rst_RsCont",     bus.RsCont,     0);
      chk("rst_alu_op",     bus.alu_op,     0);
      chk("rst_pc",         bus.pc,         0);
      chk("rst_busy",       bus.busy,       0);
      chk("rst_halted",     bus.halted,     0);
      m_mode = 0;
      m_pc   = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_all(input logic [7:0] d);
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, a, d, 1'b0);
   endtask

   function automatic logic [7:0] rand_instr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0)      return 8'hFF;
      else if (r <= 3) return 8'h80 | 8'($urandom_range(0, 63));
      else if (r == 4) return 8'hC0 | 8'($urandom_range(0, 62));
      else             return 8'($urandom_range(0, 127));
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seq_jmp[8];
      int seq_w1[4];
      int seq_w2[3];
      seq_jmp = '{0, 1, 2, 3, 1, 2, 3, 1};
      seq_w1  = '{0, 63, 0, 63};
      seq_w2  = '{0, 63, 0};

      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      bus.run        = 1'b0;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;

      async_reset();

      // MOV / ADD / HALT program
      fill_all(8'hC0);
      cycle(1'b1, 0, 8'h0A, 1'b0);
      cycle(1'b1, 1, 8'h4B, 1'b0);
      cycle(1'b1, 2, 8'hFF, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      chk("p0_instr", bus.instr_code, 8'h0A);
      chk("p0_regwrite", bus.regwrite, 1);
      idle_cycles(1);
      chk("p1_instr", bus.instr_code, 8'h4B);
      chk("p1_alu_op", bus.alu_op, 1);
      chk("p1_RsCont", bus.RsCont, 1);
      idle_cycles(1);
      chk("p2_instr", bus.instr_code, 8'hFF);
      chk("p2_regwrite", bus.regwrite, 0);
      idle_cycles(1);
      chk("halt_flag", bus.halted, 1);
      chk("halt_pc", bus.pc, 2);
      idle_cycles(2);

      // Reset in the middle of a run; memory must survive it
      for (int a = 0; a < 8; a++) cycle(1'b1, a, 8'h0A, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      idle_cycles(5);
      chk("pre_rst_pc", bus.pc, 5);
      async_reset();
      cycle(1'b0, 0, 8'h00, 1'b1);
      idle_cycles(4);
      async_reset();

      // Backward jump loop
      for (int a = 0; a < 3; a++) cycle(1'b1, a, 8'h0A, 1'b0);
      cycle(1'b1, 3, 8'hBE, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("jmp_seq", bus.pc, seq_jmp[i]);
         idle_cycles(1);
      end
      async_reset();

      // Jump wrap through address 63, then sequential wrap
      cycle(1'b1, 0, 8'hBF, 1'b0);
      cycle(1'b1, 63, 8'h81, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_jmp", bus.pc, seq_w1[i]);
         idle_cycles(1);
      end
      async_reset();
      cycle(1'b1, 63, 8'h0A, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("wrap_seq", bus.pc, seq_w2[i]);
         idle_cycles(1);
      end
      async_reset();

      // Load and run in the same cycle: first fetch sees the new word
      cycle(1'b1, 0, 8'hFF, 1'b1);
      chk("ldrun_instr", bus.instr_code, 8'hFF);
      chk("ldrun_busy", bus.busy, 1);
      idle_cycles(1);
      chk("ldrun_halted", bus.halted, 1);
      chk("ldrun_pc", bus.pc, 0);
      idle_cycles(2);

      // Loads during RUN are ignored
      for (int a = 0; a < 16; a++) cycle(1'b1, a, 8'h0A, 1'b0);
      cycle(1'b1, 16, 8'hFF, 1'b0);
      cycle(1'b0, 0, 8'h00, 1'b1);
      for (int k = 0; k < 6; k++) cycle(1'b1, m_pc + 1, 8'hFF, 1'b0);
      idle_cycles(2);
      chk("run_load_ignored", bus.halted, 0);
      chk("run_load_pc", bus.pc, 8);
      idle_cycles(12);
      chk("run_load_final", bus.halted, 1);
      async_reset();

      // Randomized programs and control traffic
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < DEPTH; a++) cycle(1'b1, a, rand_instr(), 1'b0);
         cycle(1'b0, 0, 8'h00, 1'b1);
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 99) == 0) begin
               async_reset();
            end else begin
               cycle(($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1),
                     rand_instr(), ($urandom_range(0, 7) == 0));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
